alu_mc_param: RTL and testbench

Parametrised multi-cycle integer ALU, the next generation of the team's 8-bit ALU. Operand width is set by parameter `W`, and the block uses a start/busy/done handshake. ADD and SUB complete in one cycle. MUL uses an iterative shift-add datapath and DIV uses non-restoring division, and both are driven by one shared FSM. The block adds a remainder, status flags and divide-by-zero detection, and sits between the datapath control unit and the result register file.

---
 rtl/alu_mc_param.sv | 211 +++++++++++++++++++++
 tb/tb_alu_mc_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_param.sv
// rtl/alu_mc_param.sv - parametrised multi-cycle ALU (ADD/SUB/MUL/DIV), divider built when ALU_MC_DIV_EN is defined
module alu_mc_param #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic             carry,
    output logic             zero,
    output logic             dbz
);

    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDSUB  = 3'd1,
        MUL_IT  = 3'd2,
`ifdef ALU_MC_DIV_EN
        DIV_IT  = 3'd3,
        DIV_FIX = 3'd4,
`endif
        DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
`ifdef ALU_MC_DIV_EN
    logic [W:0]       rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W:0]       rem_sh;
    logic [W:0]       rem_nxt;
    logic [W-1:0]     rem_fix;
`endif

    logic [W:0]       sum;
    logic [W:0]       diff;
    logic [W:0]       mul_hi;
    logic             fin;
    logic [2*W-1:0]   fin_res;
    logic             fin_carry;
    logic             fin_dbz;

    // Status outputs are decoded straight from the state register
    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign dbz    = dbz_q;

    // Next-state, datapath step and result capture on entry to DONE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        prod_d    = prod_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        dbz_d     = dbz_q;
        fin       = 1'b0;
        fin_res   = '0;
        fin_carry = 1'b0;
        fin_dbz   = 1'b0;

        sum    = {1'b0, a_q} + {1'b0, b_q};
        diff   = {1'b0, a_q} - {1'b0, b_q};
        // Add the multiplicand into the upper half only when the current multiplier bit is set
        mul_hi = prod_q[0] ? ({1'b0, prod_q[2*W-1:W]} + {1'b0, a_q})
                           : {1'b0, prod_q[2*W-1:W]};
`ifdef ALU_MC_DIV_EN
        rem_d   = rem_q;
        quo_d   = quo_q;
        rem_sh  = {rem_q[W-1:0], quo_q[W-1]};
        // Sign of the partial remainder picks subtract (non-negative) or add back (negative)
        rem_nxt = rem_q[W] ? (rem_sh + {1'b0, b_q}) : (rem_sh - {1'b0, b_q});
        rem_fix = rem_q[W] ? (rem_q[W-1:0] + b_q) : rem_q[W-1:0];
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    sub_d = op_sel[0];
                    cnt_d = CW'(W - 1);
                    case (op_sel)
                        2'b00, 2'b01: state_d = ADDSUB;
                        2'b10: begin
                            prod_d  = {{W{1'b0}}, b};
                            state_d = MUL_IT;
                        end
                        default: begin
`ifdef ALU_MC_DIV_EN
                            if (b != '0) begin
                                rem_d   = '0;
                                quo_d   = a;
                                state_d = DIV_IT;
                            end else begin
                                fin     = 1'b1;
                                fin_res = {a, {W{1'b1}}};
                                fin_dbz = 1'b1;
                                state_d = DONE;
                            end
`else
                            fin     = 1'b1;
                            fin_res = '0;
                            fin_dbz = 1'b1;
                            state_d = DONE;
`endif
                        end
                    endcase
                end
            end
            ADDSUB: begin
                fin       = 1'b1;
                fin_res   = sub_q ? {{W{1'b0}}, diff[W-1:0]} : {{(W-1){1'b0}}, sum};
                fin_carry = sub_q ? diff[W] : sum[W];
                state_d   = DONE;
            end
            MUL_IT: begin
                prod_d = {mul_hi, prod_q[W-1:1]};
                if (cnt_q == '0) begin
                    fin     = 1'b1;
                    fin_res = prod_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef ALU_MC_DIV_EN
            DIV_IT: begin
                rem_d = rem_nxt;
                quo_d = {quo_q[W-2:0], ~rem_nxt[W]};
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_FIX: begin
                fin     = 1'b1;
                fin_res = {rem_fix, quo_q};
                state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fin) begin
            result_d = fin_res;
            carry_d  = fin_carry;
            dbz_d    = fin_dbz;
            zero_d   = (fin_res == '0);
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            prod_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
`ifdef ALU_MC_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_mc_param.sv
// tb/tb_alu_mc_param.sv - table-driven bench for alu_mc_param (W=8 and W=16)
module tb_alu_mc_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op_sel = 2'd0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        busy, done, carry, zero, dbz;
    logic [15:0] result;

    logic        start16 = 1'b0;
    logic [1:0]  op16 = 2'd0;
    logic [15:0] a16 = 16'd0;
    logic [15:0] b16 = 16'd0;
    logic        busy16, done16, carry16, zero16, dbz16;
    logic [31:0] result16;

    int checks = 0;
    int errors = 0;
    int done_cnt8 = 0;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        d;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_mc_param #(.W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero), .dbz(dbz)
    );

    alu_mc_param #(.W(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op_sel(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .carry(carry16), .zero(zero16), .dbz(dbz16)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt8++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op on the W=8 instance; returns done latency in cycles after accept
    task automatic run8(input logic [1:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        output int lat, output int busy_cnt, output int both);
        @(negedge clk);
        op_sel = op; a = ia; b = ib; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib; op_sel = ~op;
        lat = 0; busy_cnt = 0; both = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            if (busy && done) both++;
            if (done) lat = n;
            else begin
                if (busy) busy_cnt++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int lat, bc, both, dc0, n;

        vecs.push_back(vec_t'{2'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1'b0, 2});
        vecs.push_back(vec_t'{2'd0, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back(vec_t'{2'd0, 8'd255, 8'd255, 16'h01FE, 1'b1, 1'b0, 1'b0, 2});
        vecs.push_back(vec_t'{2'd1, 8'd5,   8'd7,   16'h00FE, 1'b1, 1'b0, 1'b0, 2});
        vecs.push_back(vec_t'{2'd1, 8'd7,   8'd5,   16'h0002, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back(vec_t'{2'd1, 8'd9,   8'd9,   16'h0000, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back(vec_t'{2'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back(vec_t'{2'd2, 8'd3,   8'd4,   16'h000C, 1'b0, 1'b0, 1'b0, 9});
        vecs.push_back(vec_t'{2'd2, 8'd0,   8'd77,  16'h0000, 1'b0, 1'b1, 1'b0, 9});
        vecs.push_back(vec_t'{2'd2, 8'd128, 8'd2,   16'h0100, 1'b0, 1'b0, 1'b0, 9});
`ifdef ALU_MC_DIV_EN
        vecs.push_back(vec_t'{2'd3, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back(vec_t'{2'd3, 8'd7,   8'd200, 16'h0700, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back(vec_t'{2'd3, 8'd13,  8'd0,   16'h0DFF, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back(vec_t'{2'd0, 8'd1,   8'd2,   16'h0003, 1'b0, 1'b0, 1'b0, 2});
        vecs.push_back(vec_t'{2'd3, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0, 1'b0, 10});
        vecs.push_back(vec_t'{2'd3, 8'd0,   8'd5,   16'h0000, 1'b0, 1'b1, 1'b0, 10});
`else
        vecs.push_back(vec_t'{2'd3, 8'd200, 8'd7,   16'h0000, 1'b0, 1'b1, 1'b1, 1});
        vecs.push_back(vec_t'{2'd3, 8'd13,  8'd0,   16'h0000, 1'b0, 1'b1, 1'b1, 1});
        vecs.push_back(vec_t'{2'd0, 8'd1,   8'd2,   16'h0003, 1'b0, 1'b0, 1'b0, 2});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {carry, zero, dbz}, 0);
        chk("reset_result16", result16, 0);
        reset = 1'b0;

        // W=16 multiply
        @(negedge clk);
        op16 = 2'd2; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
        lat = 0;
        for (n = 1; n <= 40 && lat == 0; n++) begin
            if (done16) lat = n;
            else @(negedge clk);
        end
        chk("w16_mul_lat", lat, 17);
        chk("w16_mul_result", result16, 32'h0001FFFE);
        chk("w16_mul_carry", carry16, 0);

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            run8(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc, both);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].lat - 1);
            chk($sformatf("v%0d_busy_and_done", i), both, 0);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_carry", i), carry, vecs[i].c);
            chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
            chk($sformatf("v%0d_dbz", i), dbz, vecs[i].d);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {busy, done}, 0);
            chk($sformatf("v%0d_result_hold", i), result, vecs[i].res);
        end

        // MUL 3x4 with start held and operands churning while busy
        dc0 = done_cnt8;
        @(negedge clk);
        op_sel = 2'd2; a = 8'd3; b = 8'd4; start = 1'b1;
        @(negedge clk);
        lat = 0; bc = 0;
        for (n = 1; n <= 40 && lat == 0; n++) begin
            if (done) lat = n;
            else begin
                if (busy) bc++;
                a = 8'($urandom); b = 8'($urandom); op_sel = 2'($urandom);
                @(negedge clk);
            end
        end
        op_sel = 2'd2; a = 8'd9; b = 8'd9;
        chk("held_lat", lat, 9);
        chk("held_busy_cycles", bc, 8);
        chk("held_result", result, 16'h000C);
        @(negedge clk);
        start = 1'b0;
        chk("held_no_accept_in_done", {busy, done}, 0);
        chk("held_single_done", done_cnt8 - dc0, 1);

        // Reset in the middle of a long operation
        @(negedge clk);
`ifdef ALU_MC_DIV_EN
        op_sel = 2'd3; a = 8'd200; b = 8'd7;
`else
        op_sel = 2'd2; a = 8'd255; b = 8'd255;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        dc0 = done_cnt8;
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_flags", {carry, zero, dbz}, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", done_cnt8 - dc0, 0);
        run8(2'd0, 8'd1, 8'd1, lat, bc, both);
        chk("post_rst_add_lat", lat, 2);
        chk("post_rst_add_result", result, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
